win_scanner: RTL and testbench
==============================

Name: win_scanner

Overview:
- Runs after each piece drop. Walks the 8x8 board through the board store's combinational read port and decides whether the dropped piece completes a line of WIN_LENGTH in any of four directions.
- On a win, streams the winning cells one per cycle into the board store's winning-piece write path (row, col, strobe), then reports the winner.
- Sits between the drop controller (upstream, issues start) and the board store (read port plus winning-mark write).

Parameters:
WIN_LENGTH, 4, minimum run of same-colour pieces (including the dropped piece) that counts as a win; legal range 2..8

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; dropped piece is already written to the board
drop_row  input  3  row of the dropped piece
drop_col  input  3  column of the dropped piece
player  input  2  colour of the dropped piece (2'b01 or 2'b10)
rd_data  input  2  raw board cell at rd_row/rd_col, valid in the same cycle
rd_row  output  3  board read row
rd_col  output  3  board read column
mark_row  output  3  row of the winning cell being marked
mark_col  output  3  column of the winning cell being marked
mark_valid  output  1  write strobe for the winning-piece mark
busy  output  1  scan or mark in progress
done  output  1  one-cycle pulse at the end of every scan
winner  output  2  2'b00 = no win; otherwise the winning colour

Behaviour:
- Clock is clk. Reset is asynchronous, active-low on rst_n.
- Reset values: state IDLE; rd_row/rd_col/mark_row/mark_col 0; mark_valid, busy, done 0; winner 2'b00.
- Reset mid-operation aborts immediately. No further mark_valid is issued.
- Internal state:
  - 4-bit signed cursor row/col, so off-board positions -1 and 8 are representable.
  - 3-bit direction index.
  - 3-bit counts pos_cnt and neg_cnt.
  - Latched drop_row, drop_col, player.
- Directions as (dr, dc):
  - 0 horizontal (0,+1)
  - 1 vertical (+1,0)
  - 2 diagonal (+1,+1)
  - 3 anti-diagonal (+1,-1)
  - The negative pass uses (-dr, -dc).
- rd_row/rd_col = low 3 bits of the cursor while scanning, else 0.
- States:
  - IDLE:
    - start=1 latches the inputs and clears winner.
    - Sets dir=0, cursor = drop + delta, counts 0. Goes to SCAN_POS.
    - busy rises the cycle after start.
  - SCAN_POS: one cell per cycle.
    - Cursor on board and rd_data==player: pos_cnt++, cursor += delta, stay.
    - Otherwise (off board or mismatch): cursor = drop - delta, go to SCAN_NEG.
  - SCAN_NEG: same rule, stepping by -delta and counting into neg_cnt.
    - On termination, if 1+pos_cnt+neg_cnt >= WIN_LENGTH: winner=player, set mark_len = 1+pos_cnt+neg_cnt, cursor = terminating cursor + delta (the far negative end of the run), go to MARK.
    - Else if dir<3: dir++, cursor = drop + new delta, counts 0, go to SCAN_POS.
    - Else go to DONE.
  - MARK:
    - mark_valid=1 for exactly mark_len consecutive cycles.
    - mark_row/col = cursor, cursor += delta each cycle.
    - Cells are issued from the negative end to the positive end.
    - Then go to DONE (see the optional feature for the alternative).
  - DONE: done=1 for one cycle, busy=0 in that cycle, return to IDLE. winner holds until the next start or reset.
- Timing: each scan pass takes (matching cells + 1) cycles. An isolated piece with no neighbours gives done asserted 9 cycles after the start edge.
- start while busy or in DONE is ignored.
- Runs longer than WIN_LENGTH are marked in full (max 8 cells).
- rd_data==2'b11 (an already-marked cell) counts as a mismatch.

Optional Feature:
- Macro: WIN_SCANNER_ALL_LINES_EN.
- Defined:
  - After MARK, continue with the next direction (dir<3 goes to SCAN_POS, else DONE).
  - Every winning line through the drop is marked.
  - The drop cell is re-marked for each line.
- Undefined: the first winning direction ends scanning after MARK.

Test Plan:
- Lone piece player=01 at (7,0), empty elsewhere, start -> no mark_valid; done exactly 9 cycles after the start edge; winner=00.
- Row 7 cols 2,3,5 = 01, drop at (7,4), player=01 -> mark_valid for 4 cycles at (7,2),(7,3),(7,4),(7,5); winner=01; then done.
- Column 3 rows 4..6 = 10 with drop at (7,3), player=10 -> vertical win; marks (4,3),(5,3),(6,3),(7,3); winner=10.
- Diagonal (1,1)..(5,5) = 01 with drop at (3,3) -> marks 5 cells (1,1) through (5,5).
- Three-in-a-row at corner (0,0),(0,1),(0,2) -> no win. Also pulse start again while busy -> ignored, exactly one done.
- Assert rst_n=0 during MARK -> mark_valid, busy, winner go 0 immediately; IDLE after release. With WIN_SCANNER_ALL_LINES_EN, horizontal and vertical lines both through the drop cell -> both lines marked, horizontal first.

Source files
------------

// File: rtl/win_scanner.sv
// ---------------------------------------------------------------------------
// win_scanner
//
// Runs after every piece drop. Starting from the dropped cell, it walks the
// 8x8 board in four directions (horizontal, vertical, diagonal and
// anti-diagonal) through the board store's combinational read port. It counts
// same-colour neighbours on the positive side and then on the negative side of
// the drop. A line of at least WIN_LENGTH pieces (the drop included) is a win.
// The winning cells are then streamed into the board store's mark port, one
// per cycle, from the negative end to the positive end.
//
// Parameter:
//   WIN_LENGTH  minimum winning run length, 2..8 (default 4)
//
// Build option:
//   WIN_SCANNER_ALL_LINES_EN  when defined, scanning continues with the next
//                             direction after a line has been marked, so every
//                             winning line through the drop gets marked. When
//                             undefined, the first winning line ends the scan.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start                one-cycle request; the drop is already on the board
//   drop_row, drop_col   position of the dropped piece
//   player               colour of the dropped piece (2'b01 / 2'b10)
//   rd_data              board cell at rd_row/rd_col, same-cycle
//   rd_row, rd_col       board read address (0 unless scanning)
//   mark_row, mark_col   winning cell being marked
//   mark_valid           write strobe for the winning mark
//   busy                 scan or mark in progress
//   done                 one-cycle pulse at the end of every scan
//   winner               2'b00 no win, otherwise the winning colour
// ---------------------------------------------------------------------------
module win_scanner #(
  parameter int WIN_LENGTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] drop_row,
  input  logic [2:0] drop_col,
  input  logic [1:0] player,
  input  logic [1:0] rd_data,
  output logic [2:0] rd_row,
  output logic [2:0] rd_col,
  output logic [2:0] mark_row,
  output logic [2:0] mark_col,
  output logic       mark_valid,
  output logic       busy,
  output logic       done,
  output logic [1:0] winner
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_POS  = 3'd1;
  localparam logic [2:0] S_NEG  = 3'd2;
  localparam logic [2:0] S_MARK = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [3:0] WIN_LEN_C = 4'(WIN_LENGTH);

  // Row step per direction: only the horizontal direction stays on its row.
  function automatic logic signed [3:0] dir_dr(input logic [2:0] d);
    dir_dr = (d == 3'd0) ? 4'sd0 : 4'sd1;
  endfunction

  // Column step per direction: +1, 0, +1, -1.
  function automatic logic signed [3:0] dir_dc(input logic [2:0] d);
    case (d)
      3'd0:    dir_dc = 4'sd1;
      3'd1:    dir_dc = 4'sd0;
      3'd2:    dir_dc = 4'sd1;
      default: dir_dc = -4'sd1;
    endcase
  endfunction

  logic [2:0]        state_q, state_d;
  logic signed [3:0] row_q, row_d;     // cursor; -1 and 8 mean off-board
  logic signed [3:0] col_q, col_d;
  logic [2:0]        dir_q, dir_d;
  logic [2:0]        pos_cnt_q, pos_cnt_d;
  logic [2:0]        neg_cnt_q, neg_cnt_d;
  logic [3:0]        mark_cnt_q, mark_cnt_d;
  logic [2:0]        drop_row_q, drop_row_d;
  logic [2:0]        drop_col_q, drop_col_d;
  logic [1:0]        player_q, player_d;
  logic [1:0]        winner_q, winner_d;

  logic signed [3:0] dr, dc, dr_nxt, dc_nxt;
  logic signed [3:0] drop_r_s, drop_c_s;
  logic              on_board, hit;
  logic [3:0]        run_len;
  logic [2:0]        dir_inc;

  assign dir_inc  = dir_q + 3'd1;
  assign dr       = dir_dr(dir_q);
  assign dc       = dir_dc(dir_q);
  assign dr_nxt   = dir_dr(dir_inc);
  assign dc_nxt   = dir_dc(dir_inc);
  assign drop_r_s = $signed({1'b0, drop_row_q});
  assign drop_c_s = $signed({1'b0, drop_col_q});

  // Both off-board values (-1 = 4'b1111, 8 = 4'b1000) have bit 3 set.
  // A marked cell (2'b11) never equals a player colour, so it ends a run.
  assign on_board = ~row_q[3] & ~col_q[3];
  assign hit      = on_board && (rd_data == player_q);
  assign run_len  = 4'd1 + {1'b0, pos_cnt_q} + {1'b0, neg_cnt_q};

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    dir_d      = dir_q;
    pos_cnt_d  = pos_cnt_q;
    neg_cnt_d  = neg_cnt_q;
    mark_cnt_d = mark_cnt_q;
    drop_row_d = drop_row_q;
    drop_col_d = drop_col_q;
    player_d   = player_q;
    winner_d   = winner_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          drop_row_d = drop_row;
          drop_col_d = drop_col;
          player_d   = player;
          winner_d   = 2'b00;
          dir_d      = 3'd0;
          row_d      = $signed({1'b0, drop_row}) + dir_dr(3'd0);
          col_d      = $signed({1'b0, drop_col}) + dir_dc(3'd0);
          pos_cnt_d  = 3'd0;
          neg_cnt_d  = 3'd0;
          state_d    = S_POS;
        end
      end

      S_POS: begin
        if (hit) begin
          pos_cnt_d = pos_cnt_q + 3'd1;
          row_d     = row_q + dr;
          col_d     = col_q + dc;
        end else begin
          row_d   = drop_r_s - dr;
          col_d   = drop_c_s - dc;
          state_d = S_NEG;
        end
      end

      S_NEG: begin
        if (hit) begin
          neg_cnt_d = neg_cnt_q + 3'd1;
          row_d     = row_q - dr;
          col_d     = col_q - dc;
        end else if (run_len >= WIN_LEN_C) begin
          // Step back onto the last matching cell: the negative end of the run.
          winner_d   = player_q;
          mark_cnt_d = run_len;
          row_d      = row_q + dr;
          col_d      = col_q + dc;
          state_d    = S_MARK;
        end else if (dir_q < 3'd3) begin
          dir_d     = dir_inc;
          row_d     = drop_r_s + dr_nxt;
          col_d     = drop_c_s + dc_nxt;
          pos_cnt_d = 3'd0;
          neg_cnt_d = 3'd0;
          state_d   = S_POS;
        end else begin
          state_d = S_DONE;
        end
      end

      S_MARK: begin
        mark_cnt_d = mark_cnt_q - 4'd1;
        row_d      = row_q + dr;
        col_d      = col_q + dc;
        if (mark_cnt_q == 4'd1) begin
`ifdef WIN_SCANNER_ALL_LINES_EN
          if (dir_q < 3'd3) begin
            dir_d     = dir_inc;
            row_d     = drop_r_s + dr_nxt;
            col_d     = drop_c_s + dc_nxt;
            pos_cnt_d = 3'd0;
            neg_cnt_d = 3'd0;
            state_d   = S_POS;
          end else begin
            state_d = S_DONE;
          end
`else
          state_d = S_DONE;
`endif
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      row_q      <= 4'sd0;
      col_q      <= 4'sd0;
      dir_q      <= 3'd0;
      pos_cnt_q  <= 3'd0;
      neg_cnt_q  <= 3'd0;
      mark_cnt_q <= 4'd0;
      drop_row_q <= 3'd0;
      drop_col_q <= 3'd0;
      player_q   <= 2'b00;
      winner_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      dir_q      <= dir_d;
      pos_cnt_q  <= pos_cnt_d;
      neg_cnt_q  <= neg_cnt_d;
      mark_cnt_q <= mark_cnt_d;
      drop_row_q <= drop_row_d;
      drop_col_q <= drop_col_d;
      player_q   <= player_d;
      winner_q   <= winner_d;
    end
  end

  logic scanning;
  assign scanning   = (state_q == S_POS) || (state_q == S_NEG);
  assign mark_valid = (state_q == S_MARK);
  assign busy       = scanning || mark_valid;
  assign done       = (state_q == S_DONE);
  assign winner     = winner_q;
  assign rd_row     = scanning   ? row_q[2:0] : 3'd0;
  assign rd_col     = scanning   ? col_q[2:0] : 3'd0;
  assign mark_row   = mark_valid ? row_q[2:0] : 3'd0;
  assign mark_col   = mark_valid ? col_q[2:0] : 3'd0;

endmodule

// File: tb/tb_win_scanner.sv
// ---------------------------------------------------------------------------
// tb_win_scanner
//
// Directed bench for win_scanner. A behavioural 8x8 board answers the read
// port. Expected marked cells are queued before each start and popped by a
// monitor whenever mark_valid is seen. Directed steps cover a lone piece,
// horizontal / vertical / diagonal wins, a near-miss with a marked cell and
// ignored starts, reset during marking, and a drop on two lines at once.
// ---------------------------------------------------------------------------
module tb_win_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] drop_row, drop_col;
  logic [1:0] player;
  logic [1:0] rd_data;
  logic [2:0] rd_row, rd_col, mark_row, mark_col;
  logic       mark_valid, busy, done;
  logic [1:0] winner;

  logic [1:0] board [0:7][0:7];
  logic [5:0] exp_q [$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         done_cnt = 0;

  always #5 clk = ~clk;

  assign rd_data = board[rd_row][rd_col];

  win_scanner #(.WIN_LENGTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .drop_row   (drop_row),
    .drop_col   (drop_col),
    .player     (player),
    .rd_data    (rd_data),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .mark_row   (mark_row),
    .mark_col   (mark_col),
    .mark_valid (mark_valid),
    .busy       (busy),
    .done       (done),
    .winner     (winner)
  );

  task automatic chk(input int obs, input int exp, input string tag);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard side: each strobed mark must match the oldest queued cell.
  always @(negedge clk) begin
    if (rst_n && done) done_cnt++;
    if (rst_n && mark_valid) begin
      if (exp_q.size() == 0) begin
        chk({mark_row, mark_col}, 99, "unexpected mark");
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        $display("mark (%0d,%0d) expected (%0d,%0d)", mark_row, mark_col, e[5:3], e[2:0]);
        chk({mark_row, mark_col}, e, "mark cell");
      end
    end
  end

  task automatic clear_board();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        board[i][j] = 2'b00;
  endtask

  task automatic push(input logic [2:0] r, input logic [2:0] c);
    exp_q.push_back({r, c});
  endtask

  // One drop: writes the piece, pulses start, waits for done (bounded) and
  // checks busy, winner, latency (when exp_cyc > 0) and the mark queue.
  // poke re-asserts start mid-scan and in the done cycle; both must be ignored.
  task automatic run_scan(input logic [2:0] r, input logic [2:0] c, input logic [1:0] p,
                          input logic [1:0] exp_win, input int exp_cyc, input bit poke,
                          input string tag);
    int cyc;
    board[r][c] = p;
    @(negedge clk);
    drop_row = r; drop_col = c; player = p; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk(busy, 1, {tag, " busy after start"});
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 3) begin
        drop_row = 3'd5; drop_col = 3'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk(done, 1, {tag, " done seen"});
    chk(busy, 0, {tag, " busy in done cycle"});
    chk(winner, exp_win, {tag, " winner"});
    if (exp_cyc > 0) chk(cyc, exp_cyc, {tag, " done latency"});
    chk(exp_q.size(), 0, {tag, " marks outstanding"});
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk(done, 0, {tag, " done one cycle"});
    chk(winner, exp_win, {tag, " winner holds"});
    $display("scan %s: drop (%0d,%0d) winner %0d cycles %0d", tag, r, c, winner, cyc);
  endtask

  initial begin
    int d0;
    int cyc;
    rst_n = 1'b0; start = 1'b0;
    drop_row = 3'd0; drop_col = 3'd0; player = 2'b00;
    clear_board();
    repeat (3) @(negedge clk);
    chk(busy, 0, "reset busy");
    chk(done, 0, "reset done");
    chk(mark_valid, 0, "reset mark_valid");
    chk(winner, 0, "reset winner");
    chk({rd_row, rd_col, mark_row, mark_col}, 0, "reset addresses");
    rst_n = 1'b1;
    @(negedge clk);

    // Lone piece: eight one-cycle passes, done in the ninth cycle.
    run_scan(3'd7, 3'd0, 2'b01, 2'b00, 9, 1'b0, "lone");

    // Horizontal win on the bottom row.
    clear_board();
    board[7][2] = 2'b01; board[7][3] = 2'b01; board[7][5] = 2'b01;
    push(7, 2); push(7, 3); push(7, 4); push(7, 5);
`ifdef WIN_SCANNER_ALL_LINES_EN
    run_scan(3'd7, 3'd4, 2'b01, 2'b01, 16, 1'b0, "horizontal");
`else
    run_scan(3'd7, 3'd4, 2'b01, 2'b01, 10, 1'b0, "horizontal");
`endif

    // Vertical win for colour 10.
    clear_board();
    board[4][3] = 2'b10; board[5][3] = 2'b10; board[6][3] = 2'b10;
    push(4, 3); push(5, 3); push(6, 3); push(7, 3);
    run_scan(3'd7, 3'd3, 2'b10, 2'b10, 0, 1'b0, "vertical");

    // Five on the main diagonal: the whole run is marked.
    clear_board();
    board[1][1] = 2'b01; board[2][2] = 2'b01; board[4][4] = 2'b01; board[5][5] = 2'b01;
    push(1, 1); push(2, 2); push(3, 3); push(4, 4); push(5, 5);
    run_scan(3'd3, 3'd3, 2'b01, 2'b01, 0, 1'b0, "diagonal");

    // Corner three plus an already-marked cell: no win; extra starts ignored.
    clear_board();
    board[0][1] = 2'b01; board[0][2] = 2'b01; board[0][3] = 2'b11;
    d0 = done_cnt;
    run_scan(3'd0, 3'd0, 2'b01, 2'b00, 0, 1'b1, "corner");
    repeat (15) @(negedge clk);
    chk(done_cnt - d0, 1, "single done for ignored starts");
    chk(busy, 0, "idle after ignored starts");

    // Reset while marking.
    clear_board();
    board[7][2] = 2'b01; board[7][3] = 2'b01; board[7][5] = 2'b01; board[7][4] = 2'b01;
    push(7, 2); push(7, 3); push(7, 4); push(7, 5);
    @(negedge clk);
    drop_row = 3'd7; drop_col = 3'd4; player = 2'b01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (mark_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk(mark_valid, 1, "reset test reached mark");
    chk(winner, 1, "reset test winner before reset");
    #2 rst_n = 1'b0;
    #1;
    chk(mark_valid, 0, "mark_valid cleared by reset");
    chk(busy, 0, "busy cleared by reset");
    chk(winner, 0, "winner cleared by reset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk(busy, 0, "idle after reset release");
    chk(done, 0, "no done after reset release");
    $display("reset during mark: aborted after %0d cycles", cyc);
    clear_board();
    run_scan(3'd7, 3'd0, 2'b01, 2'b00, 9, 1'b0, "after reset");

    // Drop on both a horizontal and a vertical line.
    clear_board();
    board[3][1] = 2'b01; board[3][2] = 2'b01; board[3][3] = 2'b01;
    board[4][4] = 2'b01; board[5][4] = 2'b01; board[6][4] = 2'b01;
    push(3, 1); push(3, 2); push(3, 3); push(3, 4);
`ifdef WIN_SCANNER_ALL_LINES_EN
    push(3, 4); push(4, 4); push(5, 4); push(6, 4);
`endif
    run_scan(3'd3, 3'd4, 2'b01, 2'b01, 0, 1'b0, "two lines");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
